imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams words from a valid/ready source into memory,
// optionally reads them back to verify the checksum, and holds the CPU in reset until loaded.
module imem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              verify_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE, S_ERROR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     idx_q;
  logic                ver_q;
  logic [DATA_W-1:0]   vsum_q;
  logic [DATA_W-1:0]   vsum_next;
  logic                legal;
  logic                xfer;

  assign legal     = (word_count != '0) && (word_count <= DEPTH_C);
  assign s_ready   = (state == S_LOAD);
  assign xfer      = s_ready && s_valid;
  assign mem_we    = xfer;
  // idx_q doubles as the read index in VERIFY; once it reaches cnt_q only the last read data is pending.
  assign mem_re    = (state == S_VERIFY) && (idx_q < cnt_q);
  assign mem_addr  = (mem_we || mem_re) ? base_q + idx_q[ADDR_W-1:0] : '0;
  assign mem_wdata = xfer ? s_data : '0;
  assign busy      = (state == S_LOAD) || (state == S_VERIFY);
  assign done      = (state == S_DONE);
  assign vsum_next = vsum_q + mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cpu_hold <= 1'b1;
      err      <= 1'b0;
      checksum <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      ver_q    <= 1'b0;
      vsum_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cpu_hold <= 1'b1;
            if (legal) begin
              state    <= S_LOAD;
              err      <= 1'b0;
              checksum <= '0;
              base_q   <= base_addr;
              cnt_q    <= word_count;
              ver_q    <= verify_en;
              idx_q    <= '0;
              vsum_q   <= '0;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            checksum <= checksum + s_data;
            if (idx_q == cnt_q - ONE_C) begin
              idx_q <= '0;
              state <= ver_q ? S_VERIFY : S_DONE;
            end else begin
              idx_q <= idx_q + ONE_C;
            end
          end
        end
        S_VERIFY: begin
          // Read data trails mem_re by one cycle, so it is valid whenever a read was issued last cycle.
          if (idx_q != '0) vsum_q <= vsum_next;
          if (idx_q == cnt_q) begin
            if (vsum_next == checksum) begin
              state <= S_DONE;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end else begin
            idx_q <= idx_q + ONE_C;
          end
        end
        S_DONE: begin
          cpu_hold <= 1'b0;
          state    <= S_IDLE;
        end
        S_ERROR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
